// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding word read, 2-entry {inst, pc} buffer toward decode, redirect flush.
// Optional INST_FETCH_MISALIGN_FAULT_EN: a misaligned redirect raises a sticky fault and halts fetch until reset.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fault_o
);

`ifdef INST_FETCH_MISALIGN_FAULT_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_t;
`else
    typedef enum logic {S_REQ, S_WAIT} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        drop_q, drop_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] ent0_inst_q, ent0_inst_d, ent0_pc_q, ent0_pc_d;
    logic [31:0] ent1_inst_q, ent1_inst_d, ent1_pc_q, ent1_pc_d;
    logic        fault_q, fault_d;

    logic req_fire, push, pop, redir_take;

    // Request valid reacts to the same-cycle redirect, so it cannot be registered.
    assign imem_req_valid_o = ~rst_i && (state_q == S_REQ) && (count_q != 2'd2) && ~redirect_valid_i;
    assign imem_req_addr_o  = pc_q;
    assign inst_valid_o     = (count_q != 2'd0);
    assign inst_o           = ent0_inst_q;
    assign inst_pc_o        = ent0_pc_q;

    assign req_fire = imem_req_valid_o && imem_req_ready_i;
    assign push     = (state_q == S_WAIT) && imem_resp_valid_i && ~drop_q;
    assign pop      = inst_valid_o && inst_ready_i;

`ifdef INST_FETCH_MISALIGN_FAULT_EN
    assign redir_take = redirect_valid_i && (state_q != S_HALT);
    assign fault_o    = fault_q;
`else
    logic unused_redir_lsb;
    assign redir_take       = redirect_valid_i;
    assign fault_o          = 1'b0;
    assign unused_redir_lsb = ^{redirect_pc_i[1:0], fault_q};
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        drop_d      = drop_q;
        count_d     = count_q;
        ent0_inst_d = ent0_inst_q;
        ent0_pc_d   = ent0_pc_q;
        ent1_inst_d = ent1_inst_q;
        ent1_pc_d   = ent1_pc_q;
        fault_d     = fault_q;

        // Head always lives in entry 0; a pop shifts entry 1 forward.
        if (push && pop) begin
            if (count_q == 2'd1) begin
                ent0_inst_d = imem_resp_data_i;
                ent0_pc_d   = req_pc_q;
            end else begin
                ent0_inst_d = ent1_inst_q;
                ent0_pc_d   = ent1_pc_q;
                ent1_inst_d = imem_resp_data_i;
                ent1_pc_d   = req_pc_q;
            end
        end else if (pop) begin
            ent0_inst_d = ent1_inst_q;
            ent0_pc_d   = ent1_pc_q;
            count_d     = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) begin
                ent0_inst_d = imem_resp_data_i;
                ent0_pc_d   = req_pc_q;
            end else begin
                ent1_inst_d = imem_resp_data_i;
                ent1_pc_d   = req_pc_q;
            end
            count_d = count_q + 2'd1;
        end

        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid_i) begin
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: ;
        endcase

        if (redir_take) begin
            count_d = 2'd0;
            pc_d    = {redirect_pc_i[31:2], 2'b00};
            if (state_q == S_WAIT) begin
                if (imem_resp_valid_i) begin
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end else begin
                    drop_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
`ifdef INST_FETCH_MISALIGN_FAULT_EN
            if (redirect_pc_i[1:0] != 2'b00) begin
                fault_d = 1'b1;
                drop_d  = 1'b0;
                state_d = S_HALT;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            drop_q      <= 1'b0;
            count_q     <= 2'd0;
            ent0_inst_q <= 32'd0;
            ent0_pc_q   <= 32'd0;
            ent1_inst_q <= 32'd0;
            ent1_pc_q   <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            drop_q      <= drop_d;
            count_q     <= count_d;
            ent0_inst_q <= ent0_inst_d;
            ent0_pc_q   <= ent0_pc_d;
            ent1_inst_q <= ent1_inst_d;
            ent1_pc_q   <= ent1_pc_d;
            fault_q     <= fault_d;
        end
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage that sits directly upstream of the decoder. It holds the fetch PC and issues one word-aligned read at a time to instruction memory over a valid/ready request and valid response interface. Fetched words are buffered with their PC in a 2-entry FIFO and presented to the decoder over a valid/ready handshake. A one-cycle redirect from the JAL/JALR resolution path flushes the buffer and any in-flight fetch.

## Interface
- RESET_PC, 32'h8000_0000: first fetch address after reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address; bits [1:0] always 0.
- imem_resp_valid  in  1  read data valid; earliest one cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  buffer head valid.
- inst_ready  in  1  decoder consumes head.
- inst  out  32  head instruction word.
- inst_pc  out  32  PC of head instruction.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address.
- fault  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- Registers: pc (next fetch address), req_pc (address of in-flight fetch), state, drop flag, 2-entry FIFO of {inst, pc} with count 0..2.
- Reset values: pc=RESET_PC, state=REQ, drop=0, count=0, fault=0. Outputs at reset: imem_req_valid=0 during the rst cycle, inst_valid=0, inst=0, inst_pc=0, imem_req_addr=RESET_PC.
- States: REQ, WAIT, HALT (HALT only with macro).
- REQ: imem_req_valid = (count<2) & ~redirect_valid. imem_req_addr=pc. On handshake: req_pc<=pc, pc<=pc+4 (wraps modulo 2^32), go WAIT. imem_resp_valid in REQ is ignored.
- WAIT: imem_req_valid=0. On imem_resp_valid: if drop, discard and clear drop; else push {imem_resp_data, req_pc}. Go REQ either way.
- At most one outstanding request; issuing only when count<2 guarantees a push never overflows.
- FIFO: inst_valid = (count!=0); inst/inst_pc = head entry. Pop when inst_valid & inst_ready. Push and pop in the same cycle: count unchanged, order preserved.
- Redirect (highest priority): FIFO flushed (count<=0, concurrent pop and push both discarded), pc<=redirect_pc with bits [1:0] forced 0. In WAIT without same-cycle response: drop<=1, stay WAIT. In WAIT with same-cycle response: response discarded, drop<=0, go REQ. In REQ: no request issued that cycle (imem_req_valid gated), stay REQ.
- Redirect while drop already set: drop stays 1, pc updated again.

## Timing
- Request accepted cycle N, response cycle N+1 earliest, inst_valid high cycle N+2 earliest.
- Steady state with zero-wait memory and inst_ready=1: one instruction per 2 cycles.
- Redirect in cycle N: inst_valid=0 in N+1; first request to new PC asserted in N+1 if state is REQ, otherwise the cycle after the discarded response.
- rst asserted mid-fetch: all state returns to reset values next edge; a late response after reset arrives in REQ and is ignored.

## Configuration
- INST_FETCH_MISALIGN_FAULT_EN defined: redirect_valid with redirect_pc[1:0]!=0 sets fault<=1, flushes FIFO, and enters HALT; HALT issues no requests, ignores responses and redirects, and holds inst_valid=0 until rst.
- Undefined: fault tied to 0, HALT absent, redirect_pc[1:0] silently cleared.

## Test plan
- Reset release, imem_req_ready=1, 1-cycle memory, inst_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008; inst_pc sequence matches, inst equals memory contents.
- inst_ready=0 for 10 cycles -> count reaches 2, imem_req_valid stays 0; release -> both buffered words delivered in order, fetching resumes at 0x80000008.
- Redirect to 0x80000100 while in WAIT, response 3 cycles later -> stale response discarded, next inst_pc=0x80000100, no stale word delivered.
- Redirect in same cycle as a response and a pop -> FIFO empty next cycle, next request address = redirect_pc.
- pc=0xFFFFFFFC fetch -> next request address 0x00000000.
- With macro: redirect_pc=0x80000102 -> fault=1 next cycle, no further requests until rst; without macro: fetch proceeds at 0x80000100, fault=0.
